// File: rtl/cpu_pkg.sv
// Shared CPU types: next-PC source selector, fetch FSM encoding, NOP constant.
package cpu_pkg;

  // Next-PC source, also driven by the control unit.
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } pc_sel_e;

  // Fetch FSM encoding. FS_ERR is only reachable with misalignment checking built in.
  typedef enum logic [1:0] {
    FS_REQ  = 2'b00,
    FS_WAIT = 2'b01,
    FS_HOLD = 2'b10,
    FS_ERR  = 2'b11
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection. All adders wrap modulo 2^32.
module fetch_next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  pc_sel_e     pc_sel,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic [31:0] rel_pc;

  // Sequential and PC-relative targets, then pick by source.
  always_comb begin
    seq_pc  = pc + 32'd4;
    rel_pc  = pc + imm;
    next_pc = seq_pc;
    case (pc_sel)
      PC_PLUS4:  next_pc = seq_pc;
      PC_BRANCH: next_pc = branch_taken ? rel_pc : seq_pc;
      PC_JAL:    next_pc = rel_pc;
      PC_JALR:   next_pc = alu_result & ~32'h0000_0001;
      default:   next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: REQ -> WAIT -> HOLD loop against a single-request
// instruction memory, holding one instruction for decode until the control
// unit commits the next PC.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned target -> sticky
// error and ERR state; otherwise next_pc[1:0] is forced to 00).
//
// Handshake: imem_req is a one-cycle strobe with imem_addr valid in the same
// cycle; the memory answers with a one-cycle imem_valid pulse carrying
// imem_rdata one or more cycles later. imem_valid is only honoured in WAIT.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        pc_write,
  input  logic [1:0]  pc_sel,
  input  logic        branch_taken,
  input  logic        stall,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_REQ  = FS_REQ;
  localparam logic [1:0] S_WAIT = FS_WAIT;
  localparam logic [1:0] S_HOLD = FS_HOLD;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [1:0] S_ERR  = FS_ERR;
`endif

  logic [1:0]  state;
  logic        armed;      // low for the first cycle after reset release
  logic [31:0] next_pc;
  logic        commit;

  fetch_next_pc u_next_pc (
    .pc           (pc),
    .pc_sel       (pc_sel_e'(pc_sel)),
    .branch_taken (branch_taken),
    .imm          (imm),
    .alu_result   (alu_result),
    .next_pc      (next_pc)
  );

  assign commit      = (state == S_HOLD) && pc_write && !stall;
  assign imem_req    = (state == S_REQ) && armed;
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);
  assign pc_plus4    = pc + 32'd4;
  assign state_dbg   = state;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  assign misalign_err = misalign_q;

  // Sticky misalignment flag, set when a commit targets an unaligned address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_q <= 1'b0;
    else if (commit && (next_pc[1:0] != 2'b00))
      misalign_q <= 1'b1;
  end
`else
  assign misalign_err = 1'b0;
`endif

  // Fetch FSM, PC and instruction holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      armed       <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_REQ: begin
          if (armed) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            instruction <= imem_rdata;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (commit) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (next_pc[1:0] != 2'b00) begin
              state <= S_ERR;
            end else begin
              pc    <= next_pc;
              state <= S_REQ;
            end
`else
            pc    <= next_pc & ~32'h0000_0003;
            state <= S_REQ;
`endif
          end
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        S_ERR: begin
          state <= S_ERR;
        end
`endif
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, a table of next-PC commits, then
// stall, reset-during-WAIT and misaligned-JALR sequences.
// Honours FETCH_MISALIGN_CHECK_EN for the final sequence.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        pc_write;
  logic [1:0]  pc_sel;
  logic        branch_taken;
  logic        stall;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  sel;
    logic        bt;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] pc_before;
    logic [31:0] next;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[11];

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .branch_taken (branch_taken),
    .stall        (stall),
    .imm          (imm),
    .alu_result   (alu_result),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign_err (misalign_err),
    .state_dbg    (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for a request and compare its address with the scoreboard.
  task automatic wait_req(input string name);
    int k;
    logic [31:0] e;
    k = 0;
    while (imem_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
      e = 32'h0;
    end else begin
      e = exp_q.pop_front();
    end
    check({name, "_req"}, {31'b0, imem_req}, 32'd1);
    check({name, "_addr"}, imem_addr, e);
  endtask

  // Answer the outstanding request lat cycles after it was seen (lat >= 1).
  task automatic serve(input string name, input logic [31:0] rdata, input int lat);
    for (int i = 0; i < lat; i++) @(negedge clk);
    check({name, "_no_req_in_wait"}, {31'b0, imem_req}, 32'd0);
    imem_valid = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    check({name, "_iv"}, {31'b0, instr_valid}, 32'd1);
    check({name, "_instr"}, instruction, rdata);
  endtask

  task automatic commit(input logic [1:0] sel, input logic bt, input logic [31:0] im,
                        input logic [31:0] alu);
    pc_sel       = sel;
    branch_taken = bt;
    imm          = im;
    alu_result   = alu;
    pc_write     = 1'b1;
    @(negedge clk);
    pc_write     = 1'b0;
    check("commit_iv_drop", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    vt[0]  = '{2'b00, 1'b0, 32'h0,         32'h0,         32'h0000_0000, 32'h0000_0004, 32'h1111_0001};
    vt[1]  = '{2'b00, 1'b1, 32'h40,        32'h0,         32'h0000_0004, 32'h0000_0008, 32'h1111_0002};
    vt[2]  = '{2'b01, 1'b1, 32'h18,        32'h0,         32'h0000_0008, 32'h0000_0020, 32'h1111_0003};
    vt[3]  = '{2'b10, 1'b0, 32'hFFFF_FFEC, 32'h0,         32'h0000_0020, 32'h0000_000C, 32'h1111_0004};
    vt[4]  = '{2'b11, 1'b0, 32'h0,         32'h9,         32'h0000_000C, 32'h0000_0008, 32'h1111_0005};
    vt[5]  = '{2'b01, 1'b0, 32'h18,        32'h0,         32'h0000_0008, 32'h0000_000C, 32'h1111_0006};
    vt[6]  = '{2'b11, 1'b0, 32'h0,         32'h101,       32'h0000_000C, 32'h0000_0100, 32'h1111_0007};
    vt[7]  = '{2'b11, 1'b1, 32'h8,         32'hFFFF_FFFD, 32'h0000_0100, 32'hFFFF_FFFC, 32'h1111_0008};
    vt[8]  = '{2'b00, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 32'h1111_0009};
    vt[9]  = '{2'b10, 1'b0, 32'h40,        32'h0,         32'h0000_0000, 32'h0000_0040, 32'h1111_000A};
    vt[10] = '{2'b01, 1'b1, 32'hFFFF_FFF8, 32'h0,         32'h0000_0040, 32'h0000_0038, 32'h1111_000B};

    rst_n = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    pc_write = 1'b0;
    pc_sel = 2'b00;
    branch_taken = 1'b0;
    stall = 1'b0;
    imm = 32'h0;
    alu_result = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", {30'b0, state_dbg}, {30'b0, FS_REQ});
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instruction, NOP_INSTR);
    check("rst_iv", {31'b0, instr_valid}, 32'd0);
    check("rst_mis", {31'b0, misalign_err}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);

    // First request one cycle after release, then a 2-cycle memory answer
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    @(negedge clk);
    check("boot_req_cycle1", {31'b0, imem_req}, 32'd1);
    wait_req("boot");
    serve("boot", 32'h00A0_0613, 2);
    check("boot_pc", pc, 32'h0);

    // Table of commits from HOLD
    for (int i = 0; i < 11; i++) begin
      check($sformatf("v%0d_pc", i), pc, vt[i].pc_before);
      check($sformatf("v%0d_pc4", i), pc_plus4, vt[i].pc_before + 32'd4);
      exp_q.push_back(vt[i].next);
      commit(vt[i].sel, vt[i].bt, vt[i].imm, vt[i].alu);
      wait_req($sformatf("v%0d", i));
      serve($sformatf("v%0d", i), vt[i].rdata, 1 + (i % 3));
    end

    // Stall held with pc_write; stray imem_valid in HOLD must be ignored
    pc_sel = 2'b00;
    stall = 1'b1;
    pc_write = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_req", i), {31'b0, imem_req}, 32'd0);
      check($sformatf("stall%0d_iv", i), {31'b0, instr_valid}, 32'd1);
      check($sformatf("stall%0d_pc", i), pc, 32'h38);
      check($sformatf("stall%0d_instr", i), instruction, 32'h1111_000B);
    end
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    stall = 1'b0;
    exp_q.push_back(32'h3C);
    @(negedge clk);
    pc_write = 1'b0;
    check("stall_rel_iv", {31'b0, instr_valid}, 32'd0);
    wait_req("stall_rel");

    // Reset while WAIT; a late imem_valid must not be captured
    @(negedge clk);
    check("wait_state", {30'b0, state_dbg}, {30'b0, FS_WAIT});
    rst_n = 1'b0;
    #1;
    check("wrst_state", {30'b0, state_dbg}, {30'b0, FS_REQ});
    check("wrst_pc", pc, 32'h0);
    check("wrst_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    check("wrst_iv", {31'b0, instr_valid}, 32'd0);
    check("wrst_instr", instruction, NOP_INSTR);
    wait_req("wrst");
    serve("wrst", 32'h1234_5678, 1);
    check("wrst_pc_after", pc, 32'h0);

    // JALR to a target with bit1 set
    commit(2'b11, 1'b0, 32'h0, 32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_err", {31'b0, misalign_err}, 32'd1);
    check("mis_state", {30'b0, state_dbg}, {30'b0, FS_ERR});
    check("mis_pc", pc, 32'h0);
    begin
      int req_seen;
      req_seen = 0;
      pc_write = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (imem_req === 1'b1 || instr_valid === 1'b1) req_seen++;
      end
      pc_write = 1'b0;
      check("mis_no_req", req_seen, 32'd0);
      check("mis_sticky", {31'b0, misalign_err}, 32'd1);
    end
`else
    exp_q.push_back(32'h100);
    wait_req("mis_forced");
    check("mis_err_tied", {31'b0, misalign_err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
